// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: on-chip ATPG scan sequencer.
// From one start command it walks load -> capture -> unload for n_pat
// patterns, overlapping the unload of each pattern with the load of the next.
// Every output comes straight from a flop; the output decode works on the
// next state, so the enables change on the same edge as the state.
module scan_seq_ctrl #(
  parameter int LW = 10,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          srstz,
  input  logic          test_en,
  input  logic          start,
  input  logic [LW-1:0] shift_len,
  input  logic [2:0]    cap_cyc,
  input  logic [PW-1:0] n_pat,
  output logic          scan_en,
  output logic          sclk_en,
  output logic          cap_en,
  output logic          busy,
  output logic          done,
  output logic          abort,
  output logic [PW-1:0] pat_idx,
  output logic [LW-1:0] shift_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT    = 3'd1,
    S_PRE_CAP  = 3'd2,
    S_CAPTURE  = 3'd3,
    S_POST_CAP = 3'd4,
    S_UNLOAD   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t        state_reg, state_next;
  logic [LW-1:0] len_reg, len_next;         // latched shift length, already 0->1 mapped
  logic [2:0]    caplen_reg, caplen_next;   // latched capture length, already 0->1 mapped
  logic [PW-1:0] npat_reg, npat_next;
  logic [LW-1:0] shift_cnt_reg, shift_cnt_next;
  logic [2:0]    cap_cnt_reg, cap_cnt_next;
  logic [PW-1:0] pat_idx_reg, pat_idx_next;
  logic          abort_next;

  logic          scan_en_reg, scan_en_next;
  logic          sclk_en_reg, sclk_en_next;
  logic          cap_en_reg, cap_en_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          abort_reg;

  // A zero length would otherwise give an empty phase; treat it as one cycle.
  logic [LW-1:0] len_map;
  logic [2:0]    cap_map;
  logic [PW:0]   pat_inc;

  assign len_map = (shift_len == '0) ? LW'(1) : shift_len;
  assign cap_map = (cap_cyc == 3'd0) ? 3'd1 : cap_cyc;
  // One bit wider so that pat_idx + 1 never wraps when compared to n_pat.
  assign pat_inc = {1'b0, pat_idx_reg} + {{PW{1'b0}}, 1'b1};

  // State and datapath registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (!srstz) begin
      state_reg     <= S_IDLE;
      len_reg       <= '0;
      caplen_reg    <= '0;
      npat_reg      <= '0;
      shift_cnt_reg <= '0;
      cap_cnt_reg   <= '0;
      pat_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      caplen_reg    <= caplen_next;
      npat_reg      <= npat_next;
      shift_cnt_reg <= shift_cnt_next;
      cap_cnt_reg   <= cap_cnt_next;
      pat_idx_reg   <= pat_idx_next;
    end
  end

  // Next-state logic; losing test_en mid-run beats every other transition.
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    caplen_next    = caplen_reg;
    npat_next      = npat_reg;
    shift_cnt_next = shift_cnt_reg;
    cap_cnt_next   = cap_cnt_reg;
    pat_idx_next   = pat_idx_reg;
    abort_next     = 1'b0;
    if (state_reg != S_IDLE && !test_en) begin
      state_next     = S_IDLE;
      shift_cnt_next = '0;
      cap_cnt_next   = 3'd0;
      pat_idx_next   = '0;
      abort_next     = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          shift_cnt_next = '0;
          cap_cnt_next   = 3'd0;
          pat_idx_next   = '0;
          if (start && test_en) begin
            len_next    = len_map;
            caplen_next = cap_map;
            npat_next   = n_pat;
            if (n_pat != '0) begin
              state_next     = S_SHIFT;
              shift_cnt_next = len_map;
            end else begin
              state_next = S_DONE;
            end
          end
        end
        S_SHIFT, S_UNLOAD: begin
          shift_cnt_next = shift_cnt_reg - LW'(1);
          if (shift_cnt_reg == LW'(1)) begin
            state_next = (state_reg == S_SHIFT) ? S_PRE_CAP : S_DONE;
          end
        end
        S_PRE_CAP: begin
          state_next   = S_CAPTURE;
          cap_cnt_next = caplen_reg;
        end
        S_CAPTURE: begin
          cap_cnt_next = cap_cnt_reg - 3'd1;
          if (cap_cnt_reg == 3'd1) begin
            state_next = S_POST_CAP;
          end
        end
        S_POST_CAP: begin
          // Both branches start a shift of the same length: either the
          // combined unload/load of the next pattern or the final unload.
          shift_cnt_next = len_reg;
          if (pat_inc < {1'b0, npat_reg}) begin
            pat_idx_next = pat_inc[PW-1:0];
            state_next   = S_SHIFT;
          end else begin
            state_next = S_UNLOAD;
          end
        end
        S_DONE: begin
          state_next   = S_IDLE;
          pat_idx_next = '0;
        end
        default: begin
          state_next     = S_IDLE;
          shift_cnt_next = '0;
          cap_cnt_next   = 3'd0;
          pat_idx_next   = '0;
        end
      endcase
    end
  end

  // Output decode of the state being entered, so the flops line up with it.
  always_comb begin
    scan_en_next = 1'b0;
    sclk_en_next = 1'b0;
    cap_en_next  = 1'b0;
    busy_next    = 1'b1;
    done_next    = 1'b0;
    case (state_next)
      S_IDLE:     busy_next = 1'b0;
      S_SHIFT,
      S_UNLOAD: begin
        scan_en_next = 1'b1;
        sclk_en_next = 1'b1;
      end
      S_PRE_CAP:  ;
      S_CAPTURE:  cap_en_next = 1'b1;
      S_POST_CAP: scan_en_next = 1'b1;
      S_DONE:     done_next = 1'b1;
      default:    busy_next = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!srstz) begin
      scan_en_reg <= 1'b0;
      sclk_en_reg <= 1'b0;
      cap_en_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      abort_reg   <= 1'b0;
    end else begin
      scan_en_reg <= scan_en_next;
      sclk_en_reg <= sclk_en_next;
      cap_en_reg  <= cap_en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      abort_reg   <= abort_next;
    end
  end

  assign scan_en   = scan_en_reg;
  assign sclk_en   = sclk_en_reg;
  assign cap_en    = cap_en_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign abort     = abort_reg;
  assign pat_idx   = pat_idx_reg;
  assign shift_cnt = shift_cnt_reg;

endmodule
